// File: rtl/imem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0, then releases the CPU reset.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    LOAD,
    FINISH,
    RUN
  } state_t;

  state_t              state;
  logic [1:0]          lane;
  logic [31:0]         word_buf;
  logic                accept;
  logic                word_done;
  logic [31:0]         packed_word;
  logic [ADDR_WIDTH:0] committed;

  assign in_ready = (state == LOAD);

  always_comb begin
    accept      = in_valid && (state == LOAD);
    word_done   = accept && ((lane == 2'd3) || in_last);
    // Lane 0 starts a fresh word, so the other lanes come up as zero.
    packed_word = ((lane == 2'd0) ? 32'd0 : word_buf) | (32'(in_data) << {lane, 3'b000});
    // A write still in flight counts as done: word_count only catches up as mem_we drops.
    committed   = word_count + (ADDR_WIDTH + 1)'(mem_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      lane       <= 2'd0;
      word_buf   <= 32'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cpu_rst    <= 1'b1;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // NOTE: all state here uses <= so every branch sees the pre-edge values;
      // mem_we defaults low and is re-raised only for a completed word.
      mem_we <= 1'b0;
      if (mem_we) begin
        word_count <= word_count + 1'b1;
      end

      unique case (state)
        LOAD: begin
          if (accept) begin
            lane     <= lane + 2'd1;
            word_buf <= packed_word;
            if (word_done) begin
              lane <= 2'd0;
              if (committed == DEPTH) begin
                overflow <= 1'b1;
              end else begin
                mem_we    <= 1'b1;
                mem_addr  <= committed[ADDR_WIDTH-1:0];
                mem_wdata <= packed_word;
              end
            end
            if (in_last) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          state   <= RUN;
          cpu_rst <= 1'b0;
        end
        RUN: begin
          if (reload) begin
            state      <= LOAD;
            cpu_rst    <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
            lane       <= 2'd0;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a full-size and a 2-word instance
// share one byte stream and are compared against a word-level image model.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef wr_t wq_t[$];

  localparam int DEPTH_A = 1024;
  localparam int DEPTH_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        reload;

  logic        a_ready, a_we, a_cpu_rst, a_ovf;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_cnt;

  logic        b_ready, b_we, b_cpu_rst, b_ovf;
  logic [0:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  int ready_drop;

  wq_t qa, qb;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_ready), .reload(reload), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .cpu_rst(a_cpu_rst), .word_count(a_cnt), .overflow(a_ovf)
  );

  imem_loader #(.ADDR_WIDTH(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_ready), .reload(reload), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .cpu_rst(b_cpu_rst), .word_count(b_cnt), .overflow(b_ovf)
  );

  // Write monitor: each mem_we cycle is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (a_we) qa.push_back({32'(a_addr), a_wdata});
    if (b_we) qb.push_back({32'(b_addr), b_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the image is chopped into 4-byte words (short tail zero-filled when the
  // last byte was flagged), and the first DEPTH words land at addresses 0,1,2,...
  task automatic verify(input string who, input wq_t got, input bq_t img, input int n,
                        input bit last, input int depth,
                        input logic [63:0] cnt, input logic [63:0] ovf);
    int words;
    int nw;
    words = last ? (n + 3) / 4 : n / 4;
    nw    = (words < depth) ? words : depth;
    check({who, " write count"}, got.size(), nw);
    for (int w = 0; w < nw && w < got.size(); w++) begin
      logic [31:0] d;
      d = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) d[8*k +: 8] = img[4*w+k];
      end
      check($sformatf("%s addr[%0d]", who, w), got[w].addr, w);
      check($sformatf("%s data[%0d]", who, w), got[w].data, d);
    end
    check({who, " word_count"}, cnt, nw);
    check({who, " overflow"}, ovf, (words > depth) ? 1 : 0);
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, " a cpu_rst"}, a_cpu_rst, 1);
    check({tag, " a in_ready"}, a_ready, 1);
    check({tag, " a mem_we"}, a_we, 0);
    check({tag, " a mem_addr"}, a_addr, 0);
    check({tag, " a mem_wdata"}, a_wdata, 0);
    check({tag, " a word_count"}, a_cnt, 0);
    check({tag, " a overflow"}, a_ovf, 0);
    check({tag, " b word_count"}, b_cnt, 0);
    check({tag, " b overflow"}, b_ovf, 0);
    @(posedge clk); #1;
  endtask

  // Streams the first n bytes; starts and ends just after a rising edge.
  task automatic send(input bq_t img, input int n, input bit with_last, input int gap_pct);
    int i;
    int budget;
    bit acc;
    i = 0;
    budget = 0;
    ready_drop = 0;
    while (i < n) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = img[i];
        in_last  = with_last && (i == n - 1);
      end
      reload = ($urandom_range(9) == 0);
      @(negedge clk);
      if (!(a_ready && b_ready)) ready_drop++;
      acc = in_valid;
      @(posedge clk); #1;
      if (acc) i++;
      budget++;
      if (budget > 4000) begin
        check("send cycle budget", i, n);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    reload   = 1'b0;
    check("in_ready held during LOAD", ready_drop, 0);
  endtask

  task automatic load_image(input string name, input bq_t img, input int gap_pct);
    qa.delete();
    qb.delete();
    send(img, img.size(), 1'b1, gap_pct);
    @(negedge clk);
    check({name, " cpu_rst held in FINISH"}, a_cpu_rst, 1);
    check({name, " in_ready low in FINISH"}, a_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, " a cpu_rst released"}, a_cpu_rst, 0);
    check({name, " b cpu_rst released"}, b_cpu_rst, 0);
    @(posedge clk); #1;
    // Bytes offered in RUN must be ignored.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check({name, " in_ready low in RUN"}, a_ready, 0);
    check({name, " cpu_rst stays low in RUN"}, a_cpu_rst, 0);
    verify({name, " a"}, qa, img, img.size(), 1'b1, DEPTH_A, a_cnt, a_ovf);
    verify({name, " b"}, qb, img, img.size(), 1'b1, DEPTH_B, b_cnt, b_ovf);
    @(posedge clk); #1;
  endtask

  task automatic do_reload(input string name);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    check({name, " reload a cpu_rst"}, a_cpu_rst, 1);
    check({name, " reload b cpu_rst"}, b_cpu_rst, 1);
    check({name, " reload a word_count"}, a_cnt, 0);
    check({name, " reload b overflow"}, b_ovf, 0);
    check({name, " reload in_ready"}, a_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t img1, img2, img_jal, img_r, img_new;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    in_last  = 1'b0;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("power-on");
    rst = 1'b0;

    img1    = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img2    = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF};
    img_jal = '{8'h6F, 8'h00, 8'h00, 8'h00};

    load_image("img1", img1, 0);
    do_reload("img2");
    load_image("img2", img2, 0);
    do_reload("img1gap");
    load_image("img1gap", img1, 40);

    img_r.delete();
    for (int k = 0; k < 12; k++) img_r.push_back(8'($urandom));
    do_reload("ovf12");
    load_image("ovf12", img_r, 20);
    do_reload("jal");
    load_image("jal", img_jal, 0);

    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(1, 24));
      img_r.delete();
      for (int k = 0; k < len; k++) img_r.push_back(8'($urandom));
      do_reload($sformatf("rand%0d", t));
      load_image($sformatf("rand%0d", t), img_r, int'($urandom_range(0, 50)));
    end

    // Reset mid-image: word 0 is written, the partial word 1 never is.
    do_reload("midrst");
    qa.delete();
    qb.delete();
    send(img1, 6, 1'b0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    verify("midrst a", qa, img1, 6, 1'b0, DEPTH_A, a_cnt, a_ovf);
    check("midrst a cpu_rst still held", a_cpu_rst, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks("midrst");
    rst = 1'b0;
    check("midrst no write during reset", qa.size(), 1);

    img_new.delete();
    for (int k = 0; k < 4; k++) img_new.push_back(8'($urandom));
    load_image("post-rst", img_new, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
